key_schedule_seq: RTL and testbench
===================================

// Module: key_schedule_seq
// PURPOSE
//  Sequential AES-128 key schedule. Accepts one cipher key via a valid/ready handshake, iterates the
//  existing combinational round-key stage (keyexpand) once per clock, and stores all NR+1 round keys.
//  Sits upstream of the round datapath, which reads round keys by index after keys_valid rises.
// PARAMETERS
//  NR  10  number of expansion rounds; round keys 0..NR are stored; legal range 1..10 (rc = 0..NR-1)
// PORTS
//  clk         in   1          system clock; all state updates on rising edge
//  reset       in   1          synchronous, active-high reset
//  key_in      in   [15:0][7:0] cipher key, byte 0 in [0] (FIPS-197 byte order, byte 0 = LSB)
//  key_valid   in   1          key_in valid
//  key_ready   out  1          block can accept a key
//  busy        out  1          expansion in progress
//  keys_valid  out  1          all round keys 0..NR stored and consistent with last accepted key
//  rd_idx      in   4          round-key index to read
//  rd_key      out  [15:0][7:0] round key rd_idx, registered
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, cnt=0, key_ready=1, busy=0, keys_valid=0, rd_key=0;
//    round-key storage cleared to 0. Reset mid-expansion abandons the expansion; same values apply.
//  - States: IDLE, EXPAND, DONE. key_ready = (state!=EXPAND). busy = (state==EXPAND).
//  - Accept: key_valid & key_ready at edge T -> rk[0]<=key_in, cnt<=0, state<=EXPAND, keys_valid<=0.
//  - EXPAND: each edge rk[cnt+1] <= keyexpand(rk[cnt], rc=cnt); cnt<=cnt+1. When cnt==NR-1 the edge
//    also sets state<=DONE, keys_valid<=1. keys_valid is high NR cycles after the accept edge (10 default).
//  - key_valid during EXPAND is ignored (not accepted, no stall of expansion); source must hold it.
//  - DONE: keys_valid held high; a new accepted key restarts at EXPAND and drops keys_valid on that same
//    edge. IDLE->EXPAND and DONE->EXPAND are the only transitions out of IDLE/DONE.
//  - Read: rd_key <= rk[rd_idx] every edge (1-cycle latency, any state); rd_idx > NR -> rd_key <= 0.
//    During EXPAND, rd_key returns current storage contents; consumers must gate on keys_valid.
//  - Same-edge accept and read: read returns pre-update storage (write visible next cycle).
//  - rc is a 4-bit counter value 0..NR-1; no wrap occurs (cnt never exceeds NR-1 in EXPAND).
//  - All XOR/S-box arithmetic is in keyexpand; this block adds no arithmetic beyond the counter.
// STRUCTURE
//  - Shared package aes_pkg: state_t enum {IDLE,EXPAND,DONE}; typedef logic [15:0][7:0] block_t;
//    typedef logic [3:0][7:0] word_t; localparam AES128_NR=10; rcon table (shared with keyexpand).
//  - One sub-module instance: keyexpand (existing), driven by rk[cnt] and cnt. No second instance;
//    storage is an (NR+1)-entry block_t register array.
// TESTING
//  1 Reset: assert reset 2 cycles -> key_ready=1, busy=0, keys_valid=0, rd_key=0 for all rd_idx.
//  2 FIPS-197 A.1: key_in=128'h3c4fcf098815f7aba6d2ae2816157e2b, pulse key_valid in IDLE -> busy 10
//    cycles, keys_valid rises exactly 10 cycles after accept; rd_idx=1 -> 128'h05766c2a3939a323b12c548817fefaa0;
//    rd_idx=10 -> 128'ha60c63b6c80c3fe18925eec9a8f914d0; rd_idx=0 -> key_in.
//  3 Key during EXPAND: hold key_valid with a second key 3 cycles after accept -> not accepted until
//    DONE (key_ready=0 meanwhile); first key's rk[10] correct; second key accepted on first DONE cycle,
//    keys_valid drops that edge and rises 10 cycles later with second key's schedule.
//  4 Reset mid-expansion at cnt=5 -> all outputs at reset values next cycle; rd_idx=3 -> 0; new key then
//    expands correctly from scratch.
//  5 Read boundaries: rd_idx=11 and 15 -> rd_key=0; rd_idx change each cycle -> rd_key follows 1 cycle late.
//  6 Back-to-back: key_valid held high continuously with alternating keys -> each accepted on the
//    DONE cycle only, one accept per 11 cycles, schedules match software model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key schedule and the round-key stage.
//   state_t     : key-schedule sequencer states
//   block_t     : 16-byte block, byte 0 in [0] (FIPS-197 byte 0 = least significant byte)
//   word_t      : 4-byte word, byte 0 in [0]
//   AES128_NR   : expansion rounds for a 128-bit key
//   rcon()      : round constant for round-constant index 0..9
//   sbox()      : forward AES S-box lookup
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [15:0][7:0] block_t;
  typedef logic [3:0][7:0]  word_t;

  localparam int AES128_NR = 10;

  // Entry [i] is the round constant for index i.
  localparam logic [9:0][7:0] RCON_TABLE = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  // Forward S-box written in conventional reading order: entry 0x00 occupies the
  // most significant byte, entry 0xff the least significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant lookup; indices outside 0..9 contribute nothing.
  function automatic logic [7:0] rcon(input logic [3:0] rc);
    logic [7:0] val;
    if (rc < 4'd10) begin
      val = RCON_TABLE[rc];
    end else begin
      val = 8'h00;
    end
    return val;
  endfunction

  // S-box lookup; entry b sits (255 - b) bytes above the bottom of the table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = (11'd255 - {3'd0, b}) * 11'd8;
    return SBOX_TABLE[base +: 8];
  endfunction

endpackage

// File: rtl/keyexpand.sv
// Combinational AES-128 round-key stage: derives round key (rc+1) from round key rc.
//   key      in  block_t  current round key
//   rc       in  4        round-constant index 0..9
//   next_key out block_t  following round key
module keyexpand
  import aes_pkg::*;
(
  input  block_t     key,
  input  logic [3:0] rc,
  output block_t     next_key
);

  word_t w0_s, w1_s, w2_s, w3_s;
  word_t temp_s;
  word_t n0_s, n1_s, n2_s, n3_s;

  // RotWord + SubWord + Rcon on the last word, then the running XOR chain.
  always_comb begin
    w0_s = key[3:0];
    w1_s = key[7:4];
    w2_s = key[11:8];
    w3_s = key[15:12];
    // RotWord moves byte 1 into byte 0 position, byte 0 into byte 3.
    temp_s = {sbox(w3_s[0]), sbox(w3_s[3]), sbox(w3_s[2]), sbox(w3_s[1])};
    temp_s[0] = temp_s[0] ^ rcon(rc);
    n0_s = w0_s ^ temp_s;
    n1_s = w1_s ^ n0_s;
    n2_s = w2_s ^ n1_s;
    n3_s = w3_s ^ n2_s;
    next_key = {n3_s, n2_s, n1_s, n0_s};
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key schedule. Accepts a cipher key over valid/ready, runs one
// keyexpand step per clock and keeps all NR+1 round keys for indexed readback.
//   clk        in   1        system clock
//   reset      in   1        synchronous active-high reset
//   key_in     in   block_t  cipher key, byte 0 in [0]
//   key_valid  in   1        key_in valid
//   key_ready  out  1        key can be accepted (not expanding)
//   busy       out  1        expansion in progress
//   keys_valid out  1        round keys 0..NR complete for the last accepted key
//   rd_idx     in   4        round-key index to read
//   rd_key     out  block_t  round key rd_idx, one cycle after rd_idx (zero above NR)
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic       clk,
  input  logic       reset,
  input  block_t     key_in,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       keys_valid,
  input  logic [3:0] rd_idx,
  output block_t     rd_key
);

  localparam logic [3:0] LAST_CNT = 4'(NR - 1);
  localparam logic [3:0] MAX_IDX  = 4'(NR);

  state_t     state_r, state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] wr_idx_s;
  logic       accept_s;
  logic       step_s;
  logic       last_s;
  logic       key_ready_r;
  logic       busy_r;
  logic       keys_valid_r;
  block_t     rd_key_r;
  block_t     rk_r [0:NR];
  block_t     ke_out_s;

  assign key_ready  = key_ready_r;
  assign busy       = busy_r;
  assign keys_valid = keys_valid_r;
  assign rd_key     = rd_key_r;
  assign wr_idx_s   = cnt_r + 4'd1;

  keyexpand u_keyexpand (
    .key      (rk_r[cnt_r]),
    .rc       (cnt_r),
    .next_key (ke_out_s)
  );

  // Next-state decode: accept only outside EXPAND, step every EXPAND cycle.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (key_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = EXPAND;
        end else begin
          state_nxt_s = state_r;
        end
      end
      EXPAND: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = EXPAND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control state, round counter and status flags (flags track the next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      key_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      keys_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      key_ready_r <= (state_nxt_s != EXPAND);
      busy_r      <= (state_nxt_s == EXPAND);
      if (accept_s) begin
        cnt_r        <= 4'd0;
        keys_valid_r <= 1'b0;
      end else if (last_s) begin
        keys_valid_r <= 1'b1;
      end else if (step_s) begin
        cnt_r <= cnt_r + 4'd1;
      end
    end
  end

  // Round-key storage: slot 0 on accept, slot cnt+1 on each expansion step.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= NR; i++) begin
        rk_r[i] <= '0;
      end
    end else if (accept_s) begin
      rk_r[0] <= key_in;
    end else if (step_s) begin
      rk_r[wr_idx_s] <= ke_out_s;
    end
  end

  // Registered readback; sees pre-edge storage, so same-edge writes show next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_key_r <= '0;
    end else if (rd_idx <= MAX_IDX) begin
      rd_key_r <= rk_r[rd_idx];
    end else begin
      rd_key_r <= '0;
    end
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: FIPS-197 vector table, reset, hold-during-expand,
// mid-expansion reset, read boundaries and back-to-back accepts against an independent
// software model (S-box derived from GF(2^8) inversion and the affine map).
module tb_key_schedule_seq;

  logic         clk;
  logic         reset;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int checks;
  int failures;

  logic [7:0] sb_tab [256];

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [14];

  localparam logic [127:0] KA = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] KB = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KC = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KD = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KE = 128'hdeadbeefcafef00d0badc0de12345678;
  localparam logic [127:0] KF = 128'h00000000000000000000000000000000;

  key_schedule_seq dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_step(input logic [127:0] k, input int rc);
    logic [7:0]   rcv;
    logic [31:0]  t;
    logic [127:0] n;
    rcv = 8'h01;
    for (int i = 0; i < rc; i++) rcv = gmul(rcv, 8'h02);
    t[7:0]   = sb_tab[k[8*13 +: 8]] ^ rcv;
    t[15:8]  = sb_tab[k[8*14 +: 8]];
    t[23:16] = sb_tab[k[8*15 +: 8]];
    t[31:24] = sb_tab[k[8*12 +: 8]];
    n[31:0]   = k[31:0]   ^ t;
    n[63:32]  = k[63:32]  ^ n[31:0];
    n[95:64]  = k[95:64]  ^ n[63:32];
    n[127:96] = k[127:96] ^ n[95:64];
    return n;
  endfunction

  function automatic logic [127:0] model_rk(input logic [127:0] k, input int n);
    logic [127:0] r;
    r = k;
    for (int i = 0; i < n; i++) r = model_step(r, i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for keys_valid with a bound; returns cycles spent.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!keys_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic expand_key(input logic [127:0] k);
    int cyc;
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("accept_busy", 128'(busy), 128'(1'b1));
    chk("accept_ready", 128'(key_ready), 128'(1'b0));
    chk("accept_kv_low", 128'(keys_valid), 128'(1'b0));
    wait_done(cyc);
    chk("expand_latency", 128'(cyc), 128'(10));
    chk("done_busy", 128'(busy), 128'(1'b0));
    chk("done_ready", 128'(key_ready), 128'(1'b1));
  endtask

  task automatic check_schedule(input logic [127:0] k);
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      tick();
      chk($sformatf("sched_rk%0d", i), rd_key, model_rk(k, i));
    end
  endtask

  initial begin
    int cyc;
    logic [127:0] prev;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rd_idx    = 4'd0;
    build_sbox();

    // 1: reset
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 128'(key_ready), 128'(1'b1));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_kv", 128'(keys_valid), 128'(1'b0));
    chk("rst_rdkey", rd_key, 128'h0);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      chk($sformatf("rst_rd%0d", i), rd_key, 128'h0);
    end

    // 2 + 5: FIPS-197 A.1 vector table with boundary indices, index changing every cycle
    tbl[0] = '{4'd1,  128'h05766c2a3939a323b12c548817fefaa0};
    tbl[1] = '{4'd10, 128'ha60c63b6c80c3fe18925eec9a8f914d0};
    tbl[2] = '{4'd0,  KA};
    tbl[3] = '{4'd11, 128'h0};
    tbl[4] = '{4'd15, 128'h0};
    tbl[5] = '{4'd12, 128'h0};
    for (int i = 0; i < 8; i++) begin
      tbl[6 + i] = '{4'(9 - i), model_rk(KA, 9 - i)};
    end
    expand_key(KA);
    for (int i = 0; i < 14; i++) begin
      rd_idx = tbl[i].idx;
      tick();
      chk($sformatf("fips_idx%0d", tbl[i].idx), rd_key, tbl[i].exp);
    end

    // 3: key presented during EXPAND is held off until DONE
    key_in    = KC;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready_low", 128'(key_ready), 128'(1'b0));
      tick();
    end
    key_in    = KD;
    key_valid = 1'b1;
    cyc = 3;
    while (!keys_valid && cyc < 40) begin
      chk("hold_ready_wait", 128'(key_ready), 128'(1'b0));
      tick();
      cyc++;
    end
    chk("hold_first_latency", 128'(cyc), 128'(10));
    chk("hold_done_ready", 128'(key_ready), 128'(1'b1));
    rd_idx = 4'd10;
    tick();
    key_valid = 1'b0;
    chk("hold_first_rk10", rd_key, model_rk(KC, 10));
    chk("hold_second_accept_kv", 128'(keys_valid), 128'(1'b0));
    chk("hold_second_accept_busy", 128'(busy), 128'(1'b1));
    wait_done(cyc);
    chk("hold_second_latency", 128'(cyc), 128'(10));
    check_schedule(KD);

    // 4: reset in the middle of expansion
    key_in    = KE;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", 128'(key_ready), 128'(1'b1));
    chk("midrst_busy", 128'(busy), 128'(1'b0));
    chk("midrst_kv", 128'(keys_valid), 128'(1'b0));
    chk("midrst_rdkey", rd_key, 128'h0);
    rd_idx = 4'd3;
    tick();
    chk("midrst_rd3", rd_key, 128'h0);
    rd_idx = 4'd0;
    tick();
    chk("midrst_rd0", rd_key, 128'h0);
    expand_key(KF);
    check_schedule(KF);

    // 6: back-to-back with key_valid held high and alternating keys
    rd_idx    = 4'd10;
    key_in    = KA;
    key_valid = 1'b1;
    tick();
    chk("b2b_first_busy", 128'(busy), 128'(1'b1));
    prev   = KA;
    key_in = KB;
    for (int j = 0; j < 4; j++) begin
      cyc = 0;
      while (busy && cyc < 20) begin
        tick();
        cyc++;
      end
      chk("b2b_done_kv", 128'(keys_valid), 128'(1'b1));
      chk("b2b_done_ready", 128'(key_ready), 128'(1'b1));
      tick();
      cyc++;
      chk("b2b_period", 128'(cyc), 128'(11));
      chk("b2b_reaccept_busy", 128'(busy), 128'(1'b1));
      chk("b2b_reaccept_kv", 128'(keys_valid), 128'(1'b0));
      chk("b2b_prev_rk10", rd_key, model_rk(prev, 10));
      prev   = key_in;
      key_in = (key_in == KA) ? KB : KA;
    end
    key_valid = 1'b0;
    wait_done(cyc);
    chk("b2b_last_latency", 128'(cyc), 128'(10));
    check_schedule(prev);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
